// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: digest width and the digest serializer state encoding.
package sm3_pkg;

    localparam int SM3_DGST_W = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sm3_ser_state_e;

endpackage

// File: rtl/sm3_dgst_ser.sv
// Serializes a 256-bit SM3 digest into OUT_W-bit beats, word A first,
// using a valid/ready handshake on both sides.
module sm3_dgst_ser
    import sm3_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [255:0]     dgst_i,
    input  logic             dgst_vld_i,
    output logic             dgst_rdy_o,
    output logic [OUT_W-1:0] dout_o,
    output logic             dout_vld_o,
    output logic             dout_last_o,
    input  logic             dout_rdy_i
);

    localparam int BEATS = SM3_DGST_W / OUT_W;
    localparam int CNT_W = $clog2(BEATS);

    generate
        if (OUT_W != 32 && OUT_W != 64) begin : g_bad_width
            $error("sm3_dgst_ser: OUT_W must be 32 or 64");
        end
    endgenerate

    sm3_ser_state_e          state;
    logic [CNT_W-1:0]        cnt;
    logic [SM3_DGST_W-1:0]   hold;
    logic [7:0]              base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dgst_vld_i) begin
                        hold  <= dgst_i;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (dout_rdy_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BEATS - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word select is a part-select on a static hold register; only cnt toggles per beat.
    assign base        = 8'(SM3_DGST_W - 1) - 8'(OUT_W) * 8'(cnt);
    assign dout_o      = hold[base -: OUT_W];
    assign dout_vld_o  = (state == SEND);
    assign dout_last_o = (state == SEND) && (cnt == CNT_W'(BEATS - 1));
    assign dgst_rdy_o  = (state == IDLE);

endmodule

// File: tb/tb_sm3_dgst_ser.sv
// Directed bench for sm3_dgst_ser, exercising both the 32-bit and 64-bit output widths.
module tb_sm3_dgst_ser;

    logic         clk;
    logic         rst_n;

    logic [255:0] dgst_a;
    logic         vld_a;
    logic         rdy_a;
    logic [31:0]  dout_a;
    logic         ovld_a;
    logic         olast_a;
    logic         ordy_a;

    logic [255:0] dgst_b;
    logic         vld_b;
    logic         rdy_b;
    logic [63:0]  dout_b;
    logic         ovld_b;
    logic         olast_b;
    logic         ordy_b;

    int unsigned  vectors;
    int unsigned  miscompares;

    localparam logic [0:7][31:0] W_ABC = {32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                                          32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
    localparam logic [0:7][31:0] W_D2  = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                                          32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'h13579bdf};
    localparam logic [0:7][31:0] W_D3  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                          32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    localparam logic [0:7][31:0] W_D4  = {32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 32'h00000001,
                                          32'h80000000, 32'h0f0f0f0f, 32'hf0f0f0f0, 32'hc3c3c3c3};
    localparam logic [0:3][63:0] W64_ABC = {64'h66c7f0f462eeedd9, 64'hd1f2d46bdc10e4e2,
                                            64'h4167c4875cf2f7a2, 64'h297da02b8f4ba8e0};

    sm3_dgst_ser #(.OUT_W(32)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .dgst_i      (dgst_a),
        .dgst_vld_i  (vld_a),
        .dgst_rdy_o  (rdy_a),
        .dout_o      (dout_a),
        .dout_vld_o  (ovld_a),
        .dout_last_o (olast_a),
        .dout_rdy_i  (ordy_a)
    );

    sm3_dgst_ser #(.OUT_W(64)) u_dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .dgst_i      (dgst_b),
        .dgst_vld_i  (vld_b),
        .dgst_rdy_o  (rdy_b),
        .dout_o      (dout_b),
        .dout_vld_o  (ovld_b),
        .dout_last_o (olast_b),
        .dout_rdy_i  (ordy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input string tag, input int unsigned k, input logic [0:7][31:0] w);
        chk($sformatf("%s_dout%0d", tag, k), 64'(dout_a), 64'(w[k]));
        chk($sformatf("%s_vld%0d", tag, k), 64'(ovld_a), 64'd1);
        chk($sformatf("%s_last%0d", tag, k), 64'(olast_a), 64'(k == 7));
        chk($sformatf("%s_rdy%0d", tag, k), 64'(rdy_a), 64'd0);
    endtask

    task automatic idle_a(input string tag);
        chk($sformatf("%s_idle_vld", tag), 64'(ovld_a), 64'd0);
        chk($sformatf("%s_idle_last", tag), 64'(olast_a), 64'd0);
        chk($sformatf("%s_idle_rdy", tag), 64'(rdy_a), 64'd1);
    endtask

    initial begin
        logic [0:5]  pat;
        int unsigned idx;

        vectors     = 0;
        miscompares = 0;
        pat         = 6'b100101;
        rst_n  = 1'b0;
        dgst_a = '0; vld_a = 1'b0; ordy_a = 1'b0;
        dgst_b = '0; vld_b = 1'b0; ordy_b = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_dout32", 64'(dout_a), 64'd0);
        chk("rst_dout64", dout_b, 64'd0);
        chk("rst_vld64", 64'(ovld_b), 64'd0);
        idle_a("rst");
        rst_n = 1'b1;
        @(negedge clk);
        idle_a("post_rst");

        // Scenario 1: abc digest, 32-bit beats, sink always ready
        dgst_a = W_ABC; vld_a = 1'b1; ordy_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            beat_a("s1", k, W_ABC);
            @(negedge clk);
        end
        idle_a("s1_end");

        // Scenario 2: abc digest, 64-bit beats
        dgst_b = W_ABC; vld_b = 1'b1; ordy_b = 1'b1;
        @(negedge clk);
        vld_b = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            chk($sformatf("s2_dout%0d", k), dout_b, W64_ABC[k]);
            chk($sformatf("s2_vld%0d", k), 64'(ovld_b), 64'd1);
            chk($sformatf("s2_last%0d", k), 64'(olast_b), 64'(k == 3));
            chk($sformatf("s2_rdy%0d", k), 64'(rdy_b), 64'd0);
            @(negedge clk);
        end
        chk("s2_end_vld", 64'(ovld_b), 64'd0);
        chk("s2_end_rdy", 64'(rdy_b), 64'd1);

        // Scenario 3: sink backpressure pattern 1,0,0,1,0,1 repeating
        dgst_a = W_D2; vld_a = 1'b1; ordy_a = 1'b0;
        @(negedge clk);
        vld_a = 1'b0;
        idx = 0;
        for (int unsigned cyc = 0; cyc < 40 && idx < 8; cyc++) begin
            beat_a("s3", idx, W_D2);
            ordy_a = pat[cyc % 6];
            if (ordy_a) idx++;
            @(negedge clk);
        end
        chk("s3_completions", 64'(idx), 64'd8);
        idle_a("s3_end");
        ordy_a = 1'b1;

        // Scenario 4: dgst_vld_i held high across two digests
        dgst_a = W_ABC; vld_a = 1'b1;
        @(negedge clk);
        dgst_a = W_D3;
        for (int unsigned k = 0; k < 8; k++) begin
            beat_a("s4a", k, W_ABC);
            @(negedge clk);
        end
        idle_a("s4_bubble");
        @(negedge clk);
        beat_a("s4b", 0, W_D3);
        vld_a = 1'b0;
        @(negedge clk);
        for (int unsigned k = 1; k < 8; k++) begin
            beat_a("s4b", k, W_D3);
            @(negedge clk);
        end
        idle_a("s4_end");

        // Scenario 5: reset after three completed beats
        dgst_a = W_D2; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            beat_a("s5a", k, W_D2);
            @(negedge clk);
        end
        beat_a("s5a", 3, W_D2);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_dout", 64'(dout_a), 64'd0);
        idle_a("s5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_a("s5_rel");
        dgst_a = W_D4; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            beat_a("s5b", k, W_D4);
            @(negedge clk);
        end
        idle_a("s5_end");

        // Scenario 6: dgst_i churns during SEND
        dgst_a = W_D3; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            dgst_a = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
            beat_a("s6", k, W_D3);
            @(negedge clk);
        end
        idle_a("s6_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
